// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port of the fetch stage (req/gnt/rvalid).
interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order imem requests under a credit limit,
// buffers returned words with their PCs and flushes on redirect. FETCH_PERF_EN adds counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    input  logic                 stall_i,
    output logic                 valid_o,
    output logic [31:0]          instr_o,
    output logic [31:0]          pc_o,
    output logic [31:0]          fetch_cnt_o,
    output logic [31:0]          bubble_cnt_o
);
    localparam int              PTR_W  = $clog2(FIFO_DEPTH);
    localparam int              CNT_W  = PTR_W + 1;
    localparam logic [31:0]     NOP    = 32'h0000_0013;
    localparam logic [CNT_W:0]  CREDIT = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic {BOOT = 1'b0, FETCH = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    state_e           state_q, state_d;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] outstanding_q, discard_q, fifo_cnt_q, outstanding_nxt;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, tag_wr_q, tag_rd_q;
    fetch_ent_t       fifo_q [FIFO_DEPTH];
    logic [31:0]      tag_q  [FIFO_DEPTH];
    logic             credit_ok, req, grant, rsp, push, pop;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) state_q <= BOOT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: state_d = FETCH;
        endcase
    end

    always_comb begin
        req = 1'b0;
        if (state_q == FETCH) req = credit_ok;
    end

    // Words still in flight and words buffered both consume a slot, so the FIFO can never overflow.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < CREDIT;
    assign grant     = req && imem.imem_gnt_i;
    assign rsp       = imem.imem_rvalid_i && (outstanding_q != '0);
    assign push      = rsp && (discard_q == '0) && !redirect_i;
    assign pop       = valid_o && !stall_i;

    assign outstanding_nxt = outstanding_q + CNT_W'(grant) - CNT_W'(rsp);

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc_q;

    // ---------------- control state ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            outstanding_q <= outstanding_nxt;
            if (grant) tag_wr_q <= tag_wr_q + PTR_W'(1);
            if (rsp)   tag_rd_q <= tag_rd_q + PTR_W'(1);
            if (redirect_i) begin
                // Everything still in flight after this edge belongs to the old path.
                pc_q       <= redirect_pc_i & ~32'h3;
                discard_q  <= outstanding_nxt;
                fifo_cnt_q <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
            end else begin
                if (grant) pc_q <= pc_q + 32'd4;
                if (rsp && (discard_q != '0)) discard_q <= discard_q - CNT_W'(1);
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (grant) tag_q[tag_wr_q] <= pc_q;
        if (push)  fifo_q[wr_ptr_q] <= '{pc: tag_q[tag_rd_q], instr: imem.imem_rdata_i};
    end

    assign valid_o = (fifo_cnt_q != '0);
    assign instr_o = valid_o ? fifo_q[rd_ptr_q].instr : NOP;
    assign pc_o    = valid_o ? fifo_q[rd_ptr_q].pc    : 32'h0;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (pop)                 fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (!valid_o && !stall_i) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign fetch_cnt_o  = 32'h0;
    assign bubble_cnt_o = 32'h0;
`endif

    // A response with nothing in flight is a memory protocol violation; the word is ignored.
    a_rvalid_has_credit: assert property (@(posedge clk) disable iff (!rst)
        imem.imem_rvalid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model answers grants, a monitor checks deliveries.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        valid;
    logic [31:0] instr, pc, fetch_cnt, bubble_cnt;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (bus),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .stall_i      (stall),
        .valid_o      (valid),
        .instr_o      (instr),
        .pc_o         (pc),
        .fetch_cnt_o  (fetch_cnt),
        .bubble_cnt_o (bubble_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    int          n_bubbles = 0;
    int          lat = 1;
    int          cyc = 0;
    bit          rsp_hold = 1'b0;
    logic [63:0] exp_q [$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A00_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            exp_q.push_back({a, word_of(a)});
        end
    endtask

    task automatic wait_drain(input int maxc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            step();
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words still expected, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic perf_check();
`ifdef FETCH_PERF_EN
        chk("fetch_cnt", fetch_cnt, n_pops);
        chk("bubble_cnt", bubble_cnt, n_bubbles);
`else
        chk("fetch_cnt_tied", fetch_cnt, 32'h0);
        chk("bubble_cnt_tied", bubble_cnt, 32'h0);
`endif
    endtask

    // Leaves rst low; caller releases it at posedge+1.
    task automatic do_reset();
        chk("leftover_expected", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b0; redirect = 1'b0; stall = 1'b0; rsp_hold = 1'b0;
        bus.imem_gnt_i = 1'b0;
        step();
        #4;
        chk("rst_req", {31'b0, bus.imem_req_o}, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("rst_bubble_cnt", bubble_cnt, 32'h0);
        step();
        step();
    endtask

    // Memory model: grants seen before an edge are answered in order, lat cycles later.
    initial begin
        logic        g;
        logic [31:0] a;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            g = rst && bus.imem_req_o && bus.imem_gnt_i;
            a = bus.imem_addr_o;
            if (!rst) pend_q.delete();
            @(posedge clk);
            cyc++;
            if (g) pend_q.push_back('{a, cyc + lat - 1});
            #2;
            if (!rsp_hold && rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = word_of(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i  = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: every accepted head is compared against the next expected word.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                n_pops = 0;
                n_bubbles = 0;
            end else if (valid && !stall) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got pc_o=%h, want no delivery", pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", pc, e[63:32]);
                    chk("deliver_instr", instr, e[31:0]);
                end
            end else if (!valid) begin
                if (!stall) n_bubbles++;
                chk("idle_instr", instr, NOP);
                chk("idle_pc", pc, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: run did not complete, want completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        bus.imem_gnt_i = 1'b0;

        // Streaming from reset: addresses 0,4,8 and first valid three cycles after release.
        do_reset();
        lat = 1; bus.imem_gnt_i = 1'b1;
        push_exp(32'h0, 8);
        rst = 1'b1;
        step(); #4;
        chk("t1_req_c1", {31'b0, bus.imem_req_o}, 32'h1);
        chk("t1_addr_c1", bus.imem_addr_o, 32'h0);
        chk("t1_valid_c1", {31'b0, valid}, 32'h0);
        step(); #4;
        chk("t1_addr_c2", bus.imem_addr_o, 32'h4);
        chk("t1_valid_c2", {31'b0, valid}, 32'h0);
        step(); #4;
        chk("t1_valid_c3", {31'b0, valid}, 32'h1);
        chk("t1_pc_c3", pc, 32'h0);
        chk("t1_credit_req_c3", {31'b0, bus.imem_req_o}, 32'h0);
        step();
        wait_drain(60);
        stall = 1'b1;

        // Stall: buffer fills, requests stop, head is held; release delivers without loss.
        for (int i = 0; i < 6; i++) begin
            step(); #4;
            if (i >= 2) begin
                chk("t2_stall_pc", pc, 32'h20);
                chk("t2_stall_instr", instr, word_of(32'h20));
            end
        end
        chk("t2_full_req", {31'b0, bus.imem_req_o}, 32'h0);
        chk("t2_full_valid", {31'b0, valid}, 32'h1);
        step();
        push_exp(32'h20, 8);
        stall = 1'b0;
        wait_drain(60);
        stall = 1'b1;
        perf_check();

        // Reset mid-stream, two words outstanding, redirect to 0x103.
        do_reset();
        lat = 1; bus.imem_gnt_i = 1'b1; rsp_hold = 1'b1;
        rst = 1'b1;
        step(); #4;
        chk("t3_restart_addr", bus.imem_addr_o, 32'h0);
        chk("t3_restart_req", {31'b0, bus.imem_req_o}, 32'h1);
        step();
        step(); #4;
        chk("t3_two_outstanding_req", {31'b0, bus.imem_req_o}, 32'h0);
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        push_exp(32'h100, 4);
        step();
        redirect = 1'b0; rsp_hold = 1'b0;
        #4;
        chk("t3_redir_addr", bus.imem_addr_o, 32'h100);
        chk("t3_redir_req", {31'b0, bus.imem_req_o}, 32'h0);
        chk("t3_redir_valid", {31'b0, valid}, 32'h0);
        step();
        wait_drain(60);
        stall = 1'b1;
        perf_check();

        // Redirect in the same cycle as a grant and a response.
        do_reset();
        lat = 1; bus.imem_gnt_i = 1'b1;
        rst = 1'b1;
        step();
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        push_exp(32'h200, 4);
        #4;
        chk("t4_req_same_cycle", {31'b0, bus.imem_req_o}, 32'h1);
        chk("t4_addr_same_cycle", bus.imem_addr_o, 32'h4);
        step();
        redirect = 1'b0;
        #4;
        chk("t4_valid_after", {31'b0, valid}, 32'h0);
        chk("t4_addr_after", bus.imem_addr_o, 32'h200);
        chk("t4_req_after", {31'b0, bus.imem_req_o}, 32'h1);
        step();
        wait_drain(60);
        stall = 1'b1;
        perf_check();

        // Redirect during BOOT to the top word, delayed grant, PC wrap.
        do_reset();
        lat = 1; bus.imem_gnt_i = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC, 4);
        rst = 1'b1;
        step();
        redirect = 1'b0;
        #4;
        chk("t5_boot_redir_req", {31'b0, bus.imem_req_o}, 32'h1);
        chk("t5_boot_redir_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) begin
            step(); #4;
            chk("t5_hold_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
            chk("t5_hold_req", {31'b0, bus.imem_req_o}, 32'h1);
        end
        step();
        bus.imem_gnt_i = 1'b1;
        #4;
        chk("t5_grant_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        step(); #4;
        chk("t5_wrap_addr", bus.imem_addr_o, 32'h0);
        step();
        wait_drain(60);
        stall = 1'b1;
        perf_check();

        step();
        step();
        chk("final_leftover", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
